// File: rtl/seq_alu.sv
// seq_alu: clocked ALU with a start/busy/done handshake.
// Single-cycle logic/add/sub/shift ops, plus multi-cycle shift-add MUL and
// restoring DIV (one iteration per enabled cycle, WIDTH iterations).
// Ports:
//   clk, rst_n    rising-edge clock, synchronous active-low reset
//   enable        clock enable; 0 freezes every register
//   start         request, accepted when enable=1 and busy=0
//   command[3:0]  opcode
//   a, b          WIDTH-bit operands
//   busy          high while MUL/DIV iterates
//   done          one-enabled-cycle pulse marking result/flags valid
//   overflow      arithmetic overflow / borrow flag
//   error         invalid opcode or divide-by-zero
//   result        2*WIDTH-bit registered result
module seq_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               start,
    input  logic [3:0]         command,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic               error,
    output logic [2*WIDTH-1:0] result
);

    localparam int unsigned RW  = 2 * WIDTH;
    localparam int unsigned SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned CW  = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_NOT = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic [RW-1:0]    mcand_q, mcand_d;     // MUL multiplicand, shifted left per step
    logic [RW-1:0]    acc_q, acc_d;         // MUL partial product
    logic [WIDTH-1:0] quot_q, quot_d;       // MUL multiplier / DIV dividend->quotient
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [RW-1:0]    result_q, result_d;
    logic             overflow_q, overflow_d;
    logic             error_q, error_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;
    logic [RW-1:0]    shl_val;
    logic [RW-1:0]    acc_nxt;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quot_nxt;

    // State and datapath registers; reset wins over enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            mcand_q    <= '0;
            acc_q      <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            divisor_q  <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            error_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else if (enable) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            mcand_q    <= mcand_d;
            acc_q      <= acc_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            divisor_q  <= divisor_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            error_q    <= error_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state, single-cycle ops and one MUL/DIV iteration.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        divisor_d  = divisor_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        error_d    = error_q;
        done_d     = 1'b0;
        busy_d     = busy_q;

        sum     = {1'b0, a} + {1'b0, b};
        diff    = a - b;
        shamt   = b[SHW-1:0];
        shl_val = {{WIDTH{1'b0}}, a} << shamt;

        acc_nxt  = quot_q[0] ? (acc_q + mcand_q) : acc_q;
        // Restoring step: bring down the next dividend bit, keep the
        // subtraction only if it did not go negative.
        shifted  = {rem_q, quot_q[WIDTH-1]};
        trial    = shifted - {1'b0, divisor_q};
        rem_nxt  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quot_nxt = (quot_q << 1) | WIDTH'(!trial[WIDTH]);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    overflow_d = 1'b0;
                    error_d    = 1'b0;
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                    case (command)
                        OP_AND: result_d = {{WIDTH{1'b0}}, a & b};
                        OP_OR:  result_d = {{WIDTH{1'b0}}, a | b};
                        OP_XOR: result_d = {{WIDTH{1'b0}}, a ^ b};
                        OP_NOT: result_d = {{WIDTH{1'b0}}, ~a};
                        OP_ADD: begin
                            result_d   = {{(WIDTH-1){1'b0}}, sum};
                            overflow_d = sum[WIDTH];
                        end
                        OP_SUB: begin
                            result_d   = {{WIDTH{1'b0}}, diff};
                            overflow_d = (a < b);
                        end
                        OP_SHL: begin
                            result_d   = shl_val;
                            overflow_d = |shl_val[RW-1:WIDTH];
                        end
                        OP_SHR: result_d = {{WIDTH{1'b0}}, a >> shamt};
                        OP_MUL: begin
                            mcand_d  = {{WIDTH{1'b0}}, a};
                            acc_d    = '0;
                            quot_d   = b;
                            is_div_d = 1'b0;
                            cnt_d    = CW'(WIDTH);
                            busy_d   = 1'b1;
                            state_d  = S_ITER;
                            done_d   = 1'b0;
                        end
                        OP_DIV: begin
                            if (b == '0) begin
                                error_d  = 1'b1;
                                result_d = '1;
                            end else begin
                                quot_d    = a;
                                rem_d     = '0;
                                divisor_d = b;
                                is_div_d  = 1'b1;
                                cnt_d     = CW'(WIDTH);
                                busy_d    = 1'b1;
                                state_d   = S_ITER;
                                done_d    = 1'b0;
                            end
                        end
                        default: begin
                            error_d  = 1'b1;
                            result_d = '0;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ITER: begin
                cnt_d = cnt_q - CW'(1);
                if (is_div_q) begin
                    rem_d  = rem_nxt;
                    quot_d = quot_nxt;
                end else begin
                    acc_d   = acc_nxt;
                    mcand_d = mcand_q << 1;
                    quot_d  = quot_q >> 1;
                end
                if (cnt_q == CW'(1)) begin
                    result_d   = is_div_q ? {rem_nxt, quot_nxt} : acc_nxt;
                    overflow_d = !is_div_q && (|acc_nxt[RW-1:WIDTH]);
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign error    = error_q;
    assign result   = result_q;

endmodule
